// File: rtl/mp_fifo_enq_arbiter.sv
// Round-robin enqueue arbiter for a multi-port pointer FIFO.
// Packs granted producer entries onto low lanes and sequences flushes.
module mp_fifo_enq_arbiter #(
    parameter int REQ_NUM       = 8,
    parameter int ENQUEUE_WIDTH = 4,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [REQ_NUM-1:0]                     req_vld_i,
    input  logic [REQ_NUM*PAYLOAD_WIDTH-1:0]       req_payload_i,
    output logic [REQ_NUM-1:0]                     req_rdy_o,
    output logic [ENQUEUE_WIDTH-1:0]               fifo_enq_vld_o,
    output logic [ENQUEUE_WIDTH*PAYLOAD_WIDTH-1:0] fifo_enq_payload_o,
    input  logic [ENQUEUE_WIDTH-1:0]               fifo_enq_rdy_i,
    input  logic                                   flush_req_i,
    output logic                                   fifo_flush_o,
    output logic                                   busy_o
);

    localparam int PTR_W  = $clog2(REQ_NUM);
    localparam int SCAN_W = PTR_W + 1;
    localparam int CNT_W  = $clog2(ENQUEUE_WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_nxt;
    logic [PTR_W-1:0]  last_gnt;
    logic [PTR_W-1:0]  idx;
    logic [SCAN_W-1:0] scan;
    logic [CNT_W-1:0]  cap;
    logic [CNT_W-1:0]  gnt_cnt;
    logic              cap_run;
    logic              arb_en;

    // Only the contiguous ready run from lane 0 counts as capacity.
    always_comb begin
        cap     = '0;
        cap_run = 1'b1;
        for (int j = 0; j < ENQUEUE_WIDTH; j++) begin
            cap_run = cap_run & fifo_enq_rdy_i[j];
            cap     = cap + CNT_W'(cap_run);
        end
    end

    assign arb_en = !rst && (state == S_IDLE) && !flush_req_i;

    always_comb begin
        req_rdy_o          = '0;
        fifo_enq_vld_o     = '0;
        fifo_enq_payload_o = '0;
        gnt_cnt            = '0;
        last_gnt           = '0;
        scan               = '0;
        idx                = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            scan = SCAN_W'(rr_ptr) + SCAN_W'(k);
            if (scan >= SCAN_W'(REQ_NUM)) begin
                scan = scan - SCAN_W'(REQ_NUM);
            end
            idx = scan[PTR_W-1:0];
            if (arb_en && req_vld_i[idx] && (gnt_cnt < cap)) begin
                req_rdy_o[idx] = 1'b1;
                for (int j = 0; j < ENQUEUE_WIDTH; j++) begin
                    if (CNT_W'(j) == gnt_cnt) begin
                        fifo_enq_vld_o[j] = 1'b1;
                        fifo_enq_payload_o[j*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] =
                            req_payload_i[idx*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                    end
                end
                gnt_cnt  = gnt_cnt + CNT_W'(1);
                last_gnt = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        case (state)
            S_IDLE: begin
                if (flush_req_i) begin
                    state_nxt = S_FLUSH;
                end else if (gnt_cnt != '0) begin
                    rr_nxt = (last_gnt == PTR_W'(REQ_NUM - 1)) ?
                             '0 : last_gnt + PTR_W'(1);
                end
            end
            S_FLUSH: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                rr_nxt    = '0;
                state_nxt = flush_req_i ? S_FLUSH : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    assign fifo_flush_o = (state == S_FLUSH);
    assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_mp_fifo_enq_arbiter.sv
// Scoreboard bench for mp_fifo_enq_arbiter: directed arbitration,
// flush sequencing and randomized traffic.
module tb_mp_fifo_enq_arbiter;

    localparam int RN = 8;
    localparam int EW = 4;
    localparam int PW = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [RN-1:0]     vld;
    logic [RN*PW-1:0]  pl;
    logic [RN-1:0]     req_rdy;
    logic [EW-1:0]     enq_vld;
    logic [EW*PW-1:0]  enq_pl;
    logic [EW-1:0]     rdy;
    logic              flush_req;
    logic              flush_o;
    logic              busy;

    typedef struct packed {
        logic [RN-1:0]    rdy;
        logic [EW-1:0]    vld;
        logic [EW*PW-1:0] pl;
        logic             flush;
        logic             busy;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [1:0] m_st;
    logic [1:0] m_st_n;
    int         m_rr;
    int         m_rr_n;
    int         m_cap;

    mp_fifo_enq_arbiter #(
        .REQ_NUM      (RN),
        .ENQUEUE_WIDTH(EW),
        .PAYLOAD_WIDTH(PW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_vld_i         (vld),
        .req_payload_i     (pl),
        .req_rdy_o         (req_rdy),
        .fifo_enq_vld_o    (enq_vld),
        .fifo_enq_payload_o(enq_pl),
        .fifo_enq_rdy_i    (rdy),
        .flush_req_i       (flush_req),
        .fifo_flush_o      (flush_o),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        return {req_rdy, enq_vld, enq_pl, flush_o, busy};
    endfunction

    task automatic new_payloads();
        for (int r = 0; r < RN; r++) begin
            pl[r*PW +: PW] = {$urandom, $urandom};
        end
    endtask

    // Reference: build scan order from the model pointer, take the first
    // min(cap, valid) entries, and push the expected outputs.
    task automatic apply();
        exp_t e;
        int   n;
        int   last;
        int   p;
        e       = '0;
        e.flush = (m_st == 2'd1);
        e.busy  = (m_st != 2'd0);
        m_cap   = 0;
        while (m_cap < EW && rdy[m_cap] === 1'b1) m_cap++;
        n    = 0;
        last = 0;
        if (!rst && m_st == 2'd0 && !flush_req) begin
            for (int k = 0; k < RN; k++) begin
                p = (m_rr + k) % RN;
                if (vld[p] && n < m_cap) begin
                    e.rdy[p]           = 1'b1;
                    e.vld[n]           = 1'b1;
                    e.pl[n*PW +: PW]   = pl[p*PW +: PW];
                    n++;
                    last = p;
                end
            end
        end
        if (rst) begin
            m_st_n = 2'd0;
            m_rr_n = 0;
        end else if (m_st == 2'd0) begin
            m_st_n = flush_req ? 2'd1 : 2'd0;
            m_rr_n = (n > 0) ? (last + 1) % RN : m_rr;
        end else if (m_st == 2'd1) begin
            m_st_n = 2'd2;
            m_rr_n = m_rr;
        end else begin
            m_st_n = flush_req ? 2'd1 : 2'd0;
            m_rr_n = 0;
        end
        sb.push_back(e);
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_st = m_st_n;
        m_rr = m_rr_n;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t o;
        rst = 1'b1; flush_req = 1'b0; vld = '1; rdy = '1;
        new_payloads();
        apply();
        e = sb.pop_front(); o = observed(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_sb got=%h exp=%h", o, e);
        end
        vectors++;
        if ({req_rdy, enq_vld, flush_o, busy} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_outs got=%h exp=0", {req_rdy, enq_vld, flush_o, busy});
        end
        tick();
        vectors++;
        if (dut.rr_ptr !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_rr got=%0d exp=0", dut.rr_ptr);
        end
    endtask

    task automatic test_rotation();
        exp_t       e;
        exp_t       o;
        logic [7:0] g_exp[3];
        logic [2:0] r_exp[3];
        g_exp = '{8'h0F, 8'hF0, 8'h0F};
        r_exp = '{3'd4, 3'd0, 3'd4};
        rst = 1'b0; flush_req = 1'b0; vld = '1; rdy = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            new_payloads();
            apply();
            e = sb.pop_front(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rotation_sb cyc=%0d got=%h exp=%h", i, o, e);
            end
            vectors++;
            if (req_rdy !== g_exp[i]) begin
                miscompares++;
                $display("FAIL rotation_gnt cyc=%0d got=%h exp=%h", i, req_rdy, g_exp[i]);
            end
            tick();
            vectors++;
            if (dut.rr_ptr !== r_exp[i]) begin
                miscompares++;
                $display("FAIL rotation_rr cyc=%0d got=%0d exp=%0d", i, dut.rr_ptr, r_exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        exp_t o;
        rst = 1'b0; flush_req = 1'b0; rdy = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            vld = (i == 0) ? 8'b0011_0000 : 8'b1100_0010;
            new_payloads();
            apply();
            e = sb.pop_front(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wrap_sb cyc=%0d got=%h exp=%h", i, o, e);
            end
            if (i == 1) begin
                vectors++;
                if (enq_vld !== 4'b0111 ||
                    enq_pl[0*PW +: PW] !== pl[6*PW +: PW] ||
                    enq_pl[1*PW +: PW] !== pl[7*PW +: PW] ||
                    enq_pl[2*PW +: PW] !== pl[1*PW +: PW]) begin
                    miscompares++;
                    $display("FAIL wrap_lanes vld got=%b exp=0111 pl=%h", enq_vld, enq_pl);
                end
            end
            tick();
            vectors++;
            if (dut.rr_ptr !== ((i == 0) ? 3'd6 : 3'd2)) begin
                miscompares++;
                $display("FAIL wrap_rr cyc=%0d got=%0d exp=%0d", i, dut.rr_ptr, (i == 0) ? 6 : 2);
            end
        end
    endtask

    task automatic test_capacity();
        exp_t       e;
        exp_t       o;
        logic [3:0] rdy_v[3];
        logic [7:0] vld_v[3];
        logic [7:0] g_exp[3];
        logic [2:0] r_exp[3];
        rdy_v = '{4'b1111, 4'b1101, 4'b0000};
        vld_v = '{8'h80, 8'hFF, 8'hFF};
        g_exp = '{8'h80, 8'h01, 8'h00};
        r_exp = '{3'd0, 3'd1, 3'd1};
        rst = 1'b0; flush_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rdy = rdy_v[i]; vld = vld_v[i];
            new_payloads();
            apply();
            e = sb.pop_front(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL cap_sb cyc=%0d got=%h exp=%h", i, o, e);
            end
            vectors++;
            if (req_rdy !== g_exp[i]) begin
                miscompares++;
                $display("FAIL cap_gnt cyc=%0d got=%h exp=%h", i, req_rdy, g_exp[i]);
            end
            tick();
            vectors++;
            if (dut.rr_ptr !== r_exp[i]) begin
                miscompares++;
                $display("FAIL cap_rr cyc=%0d got=%0d exp=%0d", i, dut.rr_ptr, r_exp[i]);
            end
        end
    endtask

    task automatic test_flush_pulse();
        exp_t       e;
        exp_t       o;
        logic [9:0] x_exp[5];
        // {req_rdy, flush, busy}: setup, N, N+1, N+2, N+3
        x_exp = '{{8'h06, 2'b00}, {8'h00, 2'b00}, {8'h00, 2'b11},
                  {8'h00, 2'b01}, {8'h0F, 2'b00}};
        rst = 1'b0; rdy = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            vld       = (i == 0) ? 8'b0000_0110 : 8'hFF;
            flush_req = (i == 1);
            new_payloads();
            apply();
            e = sb.pop_front(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL flush_sb cyc=%0d got=%h exp=%h", i, o, e);
            end
            vectors++;
            if ({req_rdy, flush_o, busy} !== x_exp[i]) begin
                miscompares++;
                $display("FAIL flush_seq cyc=%0d got=%h exp=%h", i, {req_rdy, flush_o, busy}, x_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_flush_held();
        exp_t e;
        exp_t o;
        logic [6:0] fl_exp;
        logic [6:0] bs_exp;
        fl_exp = 7'b0001010;
        bs_exp = 7'b0011110;
        rst = 1'b0; rdy = 4'b1111; vld = '1;
        for (int i = 0; i < 7; i++) begin
            flush_req = (i < 4);
            new_payloads();
            apply();
            e = sb.pop_front(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL held_sb cyc=%0d got=%h exp=%h", i, o, e);
            end
            vectors++;
            if (flush_o !== fl_exp[i] || busy !== bs_exp[i]) begin
                miscompares++;
                $display("FAIL held_fsm cyc=%0d flush=%b busy=%b exp %b %b", i, flush_o, busy, fl_exp[i], bs_exp[i]);
            end
            if (i <= 4) begin
                vectors++;
                if (req_rdy !== 8'h00) begin
                    miscompares++;
                    $display("FAIL held_gnt cyc=%0d got=%h exp=00", i, req_rdy);
                end
            end
            if (i == 5) begin
                vectors++;
                if (req_rdy !== 8'h0F) begin
                    miscompares++;
                    $display("FAIL held_resume got=%h exp=0f", req_rdy);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_flush();
        exp_t e;
        exp_t o;
        rdy = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            flush_req = (i == 0);
            rst       = (i == 1);
            vld       = (i == 2) ? 8'h00 : 8'hFF;
            new_payloads();
            apply();
            e = sb.pop_front(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rstflush_sb cyc=%0d got=%h exp=%h", i, o, e);
            end
            if (i == 1) begin
                vectors++;
                if (flush_o !== 1'b1 || req_rdy !== 8'h00) begin
                    miscompares++;
                    $display("FAIL rstflush_in flush=%b gnt=%h exp 1 00", flush_o, req_rdy);
                end
            end
            if (i == 2) begin
                vectors++;
                if ({req_rdy, enq_vld, enq_pl, flush_o, busy} !== '0) begin
                    miscompares++;
                    $display("FAIL rstflush_after flush=%b busy=%b gnt=%h vld=%b exp all 0", flush_o, busy, req_rdy, enq_vld);
                end
            end
            if (i == 3) begin
                vectors++;
                if (req_rdy !== 8'h0F) begin
                    miscompares++;
                    $display("FAIL rstflush_grant got=%h exp=0f", req_rdy);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        exp_t e;
        exp_t o;
        int   waitc[RN];
        logic en;
        for (int r = 0; r < RN; r++) waitc[r] = 0;
        for (int i = 0; i < 10000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            flush_req = ($urandom_range(0, 49) == 0);
            vld       = RN'($urandom);
            rdy       = ($urandom_range(0, 1) == 1) ? 4'hF : EW'($urandom);
            new_payloads();
            apply();
            e = sb.pop_front(); o = observed(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL random_sb cyc=%0d got=%h exp=%h", i, o, e);
            end
            vectors++;
            if ((enq_vld & (enq_vld + 4'd1)) !== 4'd0) begin
                miscompares++;
                $display("FAIL random_contig cyc=%0d got=%b exp=thermometer", i, enq_vld);
            end
            en = !rst && m_st == 2'd0 && !flush_req && m_cap >= 4;
            for (int r = 0; r < RN; r++) begin
                if (rst || m_st == 2'd2 || !vld[r]) begin
                    waitc[r] = 0;
                end else if (en) begin
                    waitc[r] = req_rdy[r] ? 0 : waitc[r] + 1;
                    vectors++;
                    if (waitc[r] > 2) begin
                        miscompares++;
                        $display("FAIL random_fair cyc=%0d prod=%0d waited=%0d exp<=2", i, r, waitc[r]);
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush_req = 1'b0;
        vld       = '0;
        rdy       = '0;
        pl        = '0;
        m_st      = 2'd0;
        m_st_n    = 2'd0;
        m_rr      = 0;
        m_rr_n    = 0;
        m_cap     = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rotation();
        test_wrap();
        test_capacity();
        test_flush_pulse();
        test_flush_held();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
